// File: rtl/jvm_insn_framer.sv
// JVM bytecode framer: turns a byte stream into whole instructions (opcode, operands, PC tag),
// handling the wide prefix and halting on opcodes that cannot be framed until resync.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// OPCODE    | waiting for the first byte of an instruction
// WIDE      | wide prefix seen, waiting for the modified opcode
// OPER      | collecting operand bytes
// EMIT      | instruction on the output, held until out_ready
// HALT      | unsupported opcode emitted, frozen until resync
module jvm_insn_framer #(
    parameter int CNT_W        = 5,
    parameter int MAX_OPERANDS = 4,
    parameter int PC_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_byte,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_opcode,
    output logic [8*MAX_OPERANDS-1:0] out_operands,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_wide,
    output logic                      out_unsupported,
    output logic [PC_W-1:0]           out_pc,
    input  logic                      resync,
    input  logic [PC_W-1:0]           resync_pc
);

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_WIDE,
        ST_OPER,
        ST_EMIT,
        ST_HALT
    } state_t;

    localparam logic [7:0] OP_WIDE = 8'hc4;

    state_t                    state_q, state_d;
    logic [7:0]                opcode_q;
    logic [8*MAX_OPERANDS-1:0] operands_q;
    logic [CNT_W-1:0]          count_q;
    logic [CNT_W-1:0]          idx_q;
    logic [2:0]                rem_q;
    logic                      wide_q;
    logic                      unsup_q;
    logic [PC_W-1:0]           pc_q;
    logic [PC_W-1:0]           out_pc_q;

    function automatic logic [2:0] oper_len(input logic [7:0] op);
        case (op) inside
            8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3a], 8'ha9, 8'hbc:
                oper_len = 3'd1;
            8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'ha8], [8'hb2:8'hb8], 8'hbb, 8'hbd,
            8'hc0, 8'hc1, 8'hc6, 8'hc7:
                oper_len = 3'd2;
            8'hc5:
                oper_len = 3'd3;
            8'hb9, 8'hba, 8'hc8, 8'hc9:
                oper_len = 3'd4;
            default:
                oper_len = 3'd0;
        endcase
    endfunction

    function automatic logic is_unsup(input logic [7:0] op);
        is_unsup = (op == 8'haa) || (op == 8'hab) || (op >= 8'hcb);
    endfunction

    // Operand length after a wide prefix; 0 means the modified opcode cannot be widened.
    function automatic logic [2:0] wide_len(input logic [7:0] op);
        case (op) inside
            8'h84:                                    wide_len = 3'd4;
            [8'h15:8'h19], [8'h36:8'h3a], 8'ha9:     wide_len = 3'd2;
            default:                                  wide_len = 3'd0;
        endcase
    endfunction

    logic       accept;
    logic       first_byte;
    logic [2:0] op_len;
    logic       op_unsup;
    logic       op_is_wide;
    logic [2:0] wlen;
    state_t     first_state;

    assign accept      = in_valid && in_ready;
    assign first_byte  = accept && (state_q == ST_OPCODE || state_q == ST_EMIT);
    assign op_len      = oper_len(in_byte);
    assign op_unsup    = is_unsup(in_byte);
    assign op_is_wide  = (in_byte == OP_WIDE);
    assign wlen        = wide_len(in_byte);
    assign first_state = op_is_wide ? ST_WIDE :
                         (op_unsup || op_len == 3'd0) ? ST_EMIT : ST_OPER;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_OPCODE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (resync) begin
            state_d = ST_OPCODE;
        end else begin
            case (state_q)
                ST_OPCODE: if (accept) state_d = first_state;
                ST_WIDE:   if (accept) state_d = (wlen != 3'd0) ? ST_OPER : ST_EMIT;
                ST_OPER:   if (accept && rem_q == 3'd1) state_d = ST_EMIT;
                ST_EMIT: begin
                    if (accept)         state_d = first_state;
                    else if (out_ready) state_d = unsup_q ? ST_HALT : ST_OPCODE;
                end
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = (state_q == ST_EMIT);
        if (!rst && !resync) begin
            case (state_q)
                ST_OPCODE, ST_WIDE, ST_OPER: in_ready = 1'b1;
                ST_EMIT:                     in_ready = out_ready && !unsup_q;
                default:                     in_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q   <= '0;
            operands_q <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            rem_q      <= '0;
            wide_q     <= 1'b0;
            unsup_q    <= 1'b0;
            pc_q       <= '0;
            out_pc_q   <= '0;
        end else if (resync) begin
            pc_q <= resync_pc;
        end else if (accept) begin
            pc_q <= pc_q + PC_W'(1);
            if (first_byte) begin
                out_pc_q   <= pc_q;
                opcode_q   <= in_byte;
                operands_q <= '0;
                wide_q     <= op_is_wide;
                unsup_q    <= op_unsup;
                count_q    <= op_unsup ? '0 : CNT_W'(op_len);
                rem_q      <= op_unsup ? 3'd0 : op_len;
                idx_q      <= '0;
            end else if (state_q == ST_WIDE) begin
                opcode_q <= in_byte;
                unsup_q  <= (wlen == 3'd0);
                count_q  <= CNT_W'(wlen);
                rem_q    <= wlen;
            end else begin
                for (int i = 0; i < MAX_OPERANDS; i++) begin
                    if (idx_q == CNT_W'(i)) operands_q[8*i +: 8] <= in_byte;
                end
                idx_q <= idx_q + CNT_W'(1);
                rem_q <= rem_q - 3'd1;
            end
        end
    end

    assign out_opcode      = opcode_q;
    assign out_operands    = operands_q;
    assign out_count       = count_q;
    assign out_wide        = wide_q;
    assign out_unsupported = unsup_q;
    assign out_pc          = out_pc_q;

endmodule

// File: tb/tb_jvm_insn_framer.sv
// Bench for jvm_insn_framer: directed scenarios plus random instruction streams checked
// against a table-driven instruction model and an expected-output queue.
module tb_jvm_insn_framer;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_byte, out_opcode;
    logic [31:0] out_operands;
    logic [4:0]  out_count;
    logic        out_wide, out_unsupported, resync;
    logic [15:0] out_pc, resync_pc;

    jvm_insn_framer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_operands(out_operands), .out_count(out_count), .out_wide(out_wide),
        .out_unsupported(out_unsupported), .out_pc(out_pc), .resync(resync),
        .resync_pc(resync_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] opr;
        logic [4:0]  cnt;
        logic        wide;
        logic        unsup;
        logic [15:0] pc;
    } rec_t;
    typedef logic [7:0] bq_t[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          len_tab[256];
    bit          uns_tab[256];
    bit          wid_tab[256];
    logic [7:0]  wlist[12];
    logic [15:0] model_pc;
    logic [7:0]  stream[$];
    rec_t        expq[$];
    int          emit_cyc[$];
    int          acc_cyc[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void set_len(input int lo, input int hi, input int n);
        for (int i = lo; i <= hi; i++) len_tab[i] = n;
    endfunction

    task automatic build_tables();
        for (int i = 0; i < 256; i++) begin
            len_tab[i] = 0;
            uns_tab[i] = (i == 'haa) || (i == 'hab) || (i >= 'hcb);
            wid_tab[i] = 1'b0;
        end
        set_len('h10, 'h10, 1); set_len('h12, 'h12, 1); set_len('h15, 'h19, 1);
        set_len('h36, 'h3a, 1); set_len('ha9, 'ha9, 1); set_len('hbc, 'hbc, 1);
        set_len('h11, 'h11, 2); set_len('h13, 'h14, 2); set_len('h84, 'h84, 2);
        set_len('h99, 'ha8, 2); set_len('hb2, 'hb8, 2); set_len('hbb, 'hbb, 2);
        set_len('hbd, 'hbd, 2); set_len('hc0, 'hc1, 2); set_len('hc6, 'hc7, 2);
        set_len('hc5, 'hc5, 3);
        set_len('hb9, 'hba, 4); set_len('hc8, 'hc9, 4);
        wlist = '{8'h84, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19,
                  8'h36, 8'h37, 8'h38, 8'h39, 8'h3a, 8'ha9};
        foreach (wlist[i]) wid_tab[wlist[i]] = 1'b1;
    endtask

    // Expected framing of one complete instruction given as its byte list.
    function automatic rec_t model_of(input bq_t b, input logic [15:0] pc);
        rec_t r;
        int   base, n;
        r    = '0;
        r.pc = pc;
        if (b[0] == 8'hc4) begin
            r.wide = 1'b1;
            r.op   = b[1];
            base   = 2;
            n      = (b[1] == 8'h84) ? 4 : (wid_tab[b[1]] ? 2 : 0);
            r.unsup = (n == 0);
        end else begin
            r.op    = b[0];
            base    = 1;
            r.unsup = uns_tab[b[0]];
            n       = r.unsup ? 0 : len_tab[b[0]];
        end
        r.cnt = 5'(n);
        for (int k = 0; k < n; k++) r.opr = r.opr | (32'(b[base+k]) << (8*k));
        return r;
    endfunction

    function automatic rec_t mk(input logic [7:0] op, input logic [31:0] opr, input logic [4:0] cnt,
                                input logic wide, input logic unsup, input logic [15:0] pc);
        rec_t r;
        r.op = op; r.opr = opr; r.cnt = cnt; r.wide = wide; r.unsup = unsup; r.pc = pc;
        return r;
    endfunction

    function automatic rec_t cur_out();
        return mk(out_opcode, out_operands, out_count, out_wide, out_unsupported, out_pc);
    endfunction

    task automatic push_bytes(input bq_t b);
        foreach (b[i]) stream.push_back(b[i]);
        model_pc += 16'(b.size());
    endtask

    task automatic push_insn(input bq_t b);
        expq.push_back(model_of(b, model_pc));
        push_bytes(b);
    endtask

    task automatic gen_insn();
        bq_t        b;
        int         op;
        logic [7:0] m;
        if ($urandom_range(0, 4) == 0) begin
            m = wlist[$urandom_range(0, 11)];
            b.push_back(8'hc4);
            b.push_back(m);
            repeat ((m == 8'h84) ? 4 : 2) b.push_back(8'($urandom_range(0, 255)));
        end else begin
            do op = $urandom_range(0, 255); while (uns_tab[op] || op == 'hc4);
            b.push_back(8'(op));
            repeat (len_tab[op]) b.push_back(8'($urandom_range(0, 255)));
        end
        push_insn(b);
    endtask

    task automatic cmp_rec(input string t, input rec_t g, input rec_t e);
        check_val({t, ".opcode"},   64'(g.op),    64'(e.op));
        check_val({t, ".operands"}, 64'(g.opr),   64'(e.opr));
        check_val({t, ".count"},    64'(g.cnt),   64'(e.cnt));
        check_val({t, ".wide"},     64'(g.wide),  64'(e.wide));
        check_val({t, ".unsup"},    64'(g.unsup), 64'(e.unsup));
        check_val({t, ".pc"},       64'(g.pc),    64'(e.pc));
    endtask

    // Drive the pending byte stream and score emissions; fed_only stops once all bytes are taken.
    task automatic run(input int budget, input int valid_pct, input int ready_pct, input bit fed_only);
        int   n;
        bit   prev_stall;
        rec_t prev;
        n = 0;
        prev_stall = 1'b0;
        prev = '0;
        while ((fed_only ? (stream.size() > 0) : (stream.size() > 0 || expq.size() > 0)) && n < budget) begin
            @(negedge clk);
            in_valid  = (stream.size() > 0) && ($urandom_range(1, 100) <= valid_pct);
            in_byte   = (stream.size() > 0) ? stream[0] : 8'h00;
            out_ready = ($urandom_range(1, 100) <= ready_pct);
            #1;
            if (prev_stall) begin
                check_val("hold.valid", 64'(out_valid), 64'd1);
                cmp_rec("hold", cur_out(), prev);
            end
            prev_stall = out_valid && !out_ready;
            prev       = cur_out();
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check_val("spurious_emit", 64'(out_valid), 64'd0);
                end else begin
                    cmp_rec("emit", cur_out(), expq.pop_front());
                    emit_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) begin
                void'(stream.pop_front());
                acc_cyc.push_back(cyc);
            end
            n++;
            cyc++;
        end
        check_val("run_pending", 64'(fed_only ? stream.size() : stream.size() + expq.size()), 64'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; resync = 1'b0; in_valid = 1'b1; in_byte = 8'h60; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_val("rst.in_ready",  64'(in_ready),  64'd0);
        check_val("rst.out_valid", 64'(out_valid), 64'd0);
        cmp_rec("rst", cur_out(), '0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_pc = '0;
        stream.delete();
        expq.delete();
    endtask

    task automatic do_resync(input logic [15:0] pc);
        @(negedge clk);
        resync = 1'b1; resync_pc = pc; in_valid = 1'b1; in_byte = 8'h00;
        #1;
        check_val("resync.in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        resync = 1'b0; in_valid = 1'b0;
        model_pc = pc;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t b;
        rst = 1'b1; in_valid = 1'b0; in_byte = '0; out_ready = 1'b0;
        resync = 1'b0; resync_pc = '0;
        build_tables();

        // back-to-back zero-operand opcodes
        do_reset();
        b = {8'h60, 8'h60, 8'h60};
        push_bytes(b);
        for (int i = 0; i < 3; i++) expq.push_back(mk(8'h60, 0, 0, 0, 0, 16'(i)));
        emit_cyc.delete(); acc_cyc.delete();
        run(50, 100, 100, 0);
        check_val("b2b.n", 64'(emit_cyc.size()), 64'd3);
        for (int i = 0; i < 3 && i < emit_cyc.size() && i < acc_cyc.size(); i++) begin
            check_val("b2b.latency", 64'(emit_cyc[i] - acc_cyc[i]), 64'd1);
            check_val("b2b.spacing", 64'(emit_cyc[i] - emit_cyc[0]), 64'(i));
        end

        // operand assembly
        do_reset();
        b = {8'h11, 8'h12, 8'h34, 8'h10, 8'h7f};
        push_bytes(b);
        expq.push_back(mk(8'h11, 32'h0000_3412, 5'd2, 0, 0, 16'd0));
        expq.push_back(mk(8'h10, 32'h0000_007f, 5'd1, 0, 0, 16'd3));
        run(100, 70, 50, 0);

        // wide iinc
        do_reset();
        b = {8'hc4, 8'h84, 8'h01, 8'h00, 8'hff, 8'hfe};
        push_bytes(b);
        expq.push_back(mk(8'h84, 32'hfeff_0001, 5'd4, 1, 0, 16'd0));
        run(100, 100, 100, 0);

        // output stall: held stable, no byte taken
        do_reset();
        b = {8'hb9, 8'h01, 8'h02, 8'h03, 8'h04};
        push_bytes(b);
        run(50, 100, 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_byte = 8'h60; out_ready = 1'b0;
            #1;
            check_val("stall.valid",    64'(out_valid), 64'd1);
            check_val("stall.in_ready", 64'(in_ready),  64'd0);
            cmp_rec("stall", cur_out(), mk(8'hb9, 32'h0403_0201, 5'd4, 0, 0, 16'd0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        expq.push_back(mk(8'hb9, 32'h0403_0201, 5'd4, 0, 0, 16'd0));
        run(20, 100, 100, 0);
        @(negedge clk);
        #1;
        check_val("stall.single", 64'(out_valid), 64'd0);

        // unsupported -> halt -> resync
        do_reset();
        b = {8'haa};
        push_bytes(b);
        expq.push_back(mk(8'haa, 0, 0, 0, 1, 16'd0));
        run(50, 100, 100, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_byte = 8'h00; out_ready = 1'b1;
            #1;
            check_val("halt.in_ready",  64'(in_ready),  64'd0);
            check_val("halt.out_valid", 64'(out_valid), 64'd0);
        end
        do_resync(16'h0100);
        b = {8'h00};
        push_bytes(b);
        expq.push_back(mk(8'h00, 0, 0, 0, 0, 16'h0100));
        run(50, 100, 100, 0);
        b = {8'hc4, 8'h60};
        push_bytes(b);
        expq.push_back(mk(8'h60, 0, 0, 1, 1, 16'h0101));
        run(50, 100, 100, 0);

        // PC wrap across 0xffff
        do_resync(16'hfff0);
        for (int i = 0; i < 17; i++) begin
            b = {8'(8'h60 + i)};
            push_insn(b);
        end
        check_val("wrap.model_last_pc", 64'(expq[16].pc), 64'h0);
        run(200, 100, 100, 0);

        // resync while holding an instruction
        do_reset();
        b = {8'h60};
        push_bytes(b);
        run(20, 100, 0, 1);
        @(negedge clk);
        #1;
        check_val("rsemit.valid_before", 64'(out_valid), 64'd1);
        do_resync(16'h0200);
        #1;
        check_val("rsemit.valid_after", 64'(out_valid), 64'd0);
        b = {8'h00};
        push_bytes(b);
        expq.push_back(mk(8'h00, 0, 0, 0, 0, 16'h0200));
        run(50, 100, 100, 0);

        // reset mid-instruction discards it
        do_reset();
        b = {8'h11, 8'h12};
        push_bytes(b);
        run(50, 100, 100, 1);
        do_reset();
        b = {8'h00};
        push_bytes(b);
        expq.push_back(mk(8'h00, 0, 0, 0, 0, 16'h0000));
        run(50, 100, 100, 0);

        // random streams
        do_reset();
        repeat (300) gen_insn();
        run(20000, 75, 60, 0);
        repeat (200) gen_insn();
        run(20000, 100, 100, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
